sample_frame_sequencer: RTL
===========================

SAMPLE_FRAME_SEQUENCER -- requirements
Module: sample_frame_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, 32, AXI-Stream word width on both sides.
REQ-002 Parameter SAMPLE_WIDTH, 24, audio sample width, left-justified in TDATA[31:8].
REQ-003 Parameter FRAME_LEN, 1024, mono samples per output frame; power of two, 2..65536.
REQ-004 Parameter FIFO_DEPTH, 4, output buffer depth in samples.
REQ-005 One clock; reset is asynchronous and active-low: clk  in  1  system clock (22.579 MHz audio clock); resetn  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  level; 1 = capture and frame audio, 0 = stop at next frame boundary.
REQ-007 S_AXIS_TVALID  in  1; S_AXIS_TREADY  out  1; S_AXIS_TDATA  in  32; S_AXIS_TLAST  in  1: stereo words from I2S receiver, TLAST=1 marks the right-channel word.
REQ-008 M_AXIS_TVALID  out  1; M_AXIS_TREADY  in  1; M_AXIS_TDATA  out  32; M_AXIS_TLAST  out  1 (last sample of frame).
REQ-009 busy  out  1  high in any state other than IDLE or while FIFO non-empty.
REQ-010 overflow_count  out  16  samples dropped on full FIFO, saturating at 0xFFFF.
REQ-011 resync_count  out  16  channel-order errors detected, saturating at 0xFFFF.
REQ-012 frame_count  out  16  frames completed (TLAST written to FIFO), wraps 0xFFFF->0.

Function
REQ-013 S_AXIS_TREADY SHALL be 1 whenever resetn=1; the audio source is never back-pressured.
REQ-014 FSM states SHALL be IDLE, ALIGN, LEFT, RIGHT; handshake = S_AXIS_TVALID & S_AXIS_TREADY.
REQ-015 IDLE -> ALIGN when enable=1; words accepted in IDLE are discarded.
REQ-016 ALIGN: discard words; on handshake with TLAST=1 -> LEFT (next word is left).
REQ-017 LEFT: handshake with TLAST=0 latches L=TDATA[31:8], -> RIGHT; handshake with TLAST=1 -> resync_count+1, stay LEFT, word discarded.
REQ-018 RIGHT: handshake with TLAST=1 -> produce mono sample, -> LEFT; handshake with TLAST=0 -> resync_count+1, discard L, latch this word as new L, stay RIGHT.
REQ-019 Mono = (sext25(L) + sext25(R)) >>> 1, truncated to 24 bits two's-complement; M_AXIS_TDATA = {mono, 8'h00}.
REQ-020 Mono sample SHALL be written to FIFO on the cycle after the right-word handshake; with FIFO empty, M_AXIS_TVALID rises one cycle after the write (2-cycle latency from right handshake).
REQ-021 Sample index counter 0..FRAME_LEN-1 SHALL advance only on a successful FIFO write; the write at index FRAME_LEN-1 carries TLAST=1, increments frame_count, and wraps the index to 0.
REQ-022 FIFO full at write time: sample dropped, overflow_count+1, index unchanged.
REQ-023 Output SHALL obey AXI-Stream: TDATA/TLAST stable while TVALID=1 and TREADY=0; simultaneous FIFO read and write when full SHALL NOT drop.
REQ-024 enable=0 with index=0 and state LEFT/ALIGN: -> IDLE next cycle; with index!=0: continue until TLAST is written, then -> IDLE.
REQ-025 enable re-asserted before the pending stop completes SHALL cancel the stop without gap or index reset.
REQ-026 FIFO contents SHALL drain to M_AXIS in IDLE.
REQ-027 Counter increments coinciding with saturation SHALL hold 0xFFFF.

Reset
REQ-028 resetn=0 SHALL asynchronously force: state IDLE, index 0, FIFO empty, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0, busy=0, all counters 0, stop-pending cleared.
REQ-029 Reset mid-frame SHALL discard the partial frame; next frame starts at index 0 after ALIGN.

Structure
REQ-030 Shared package audio_pkg SHALL hold DATA_WIDTH, SAMPLE_WIDTH, FRAME_LEN default and FSM state encodings.
REQ-031 Output buffer SHALL be sub-module sample_fifo (synchronous, FIFO_DEPTH entries of 33 bits = TLAST+TDATA, same clk/resetn).

Verification
REQ-032 L=0x7FFFFF, R=0x7FFFFF, TREADY=1 -> M_AXIS_TDATA=0x7FFFFF00; L=0x800000,R=0x800000 -> 0x80000000; L=0x000001,R=0xFFFFFE -> 0xFFFFFF00.
REQ-033 FRAME_LEN=8, 20 stereo pairs, TREADY=1 -> TLAST on samples 8 and 16, frame_count=2, no drops.
REQ-034 FRAME_LEN=8, TREADY=0 for 10 pairs -> 4 samples buffered, overflow_count=6, index=4; release -> 4 samples out, next TLAST after 4 more writes.
REQ-035 Inject two consecutive TLAST=1 words while in LEFT -> resync_count=1, following pair produces correct mono.
REQ-036 FRAME_LEN=8, drop enable after sample 3 -> samples 4..8 still produced, TLAST on 8, then IDLE, busy=0 after drain; re-enable at sample 5 -> no stop.
REQ-037 Assert resetn=0 mid-frame at sample 5 -> all outputs at reset values immediately; after release, first TLAST after 8 new samples.

Source files
------------

// File: rtl/sample_frame_sequencer_pkg.sv
// audio_pkg: shared widths, defaults, sequencer state encodings and counter helper
package audio_pkg;
    localparam int AUDIO_DATA_WIDTH   = 32;
    localparam int AUDIO_SAMPLE_WIDTH = 24;
    localparam int AUDIO_FRAME_LEN    = 1024;
    localparam int AUDIO_FIFO_DEPTH   = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_LEFT  = 2'd2;
    localparam logic [1:0] ST_RIGHT = 2'd3;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/sample_frame_sequencer_fifo.sv
// sample_fifo: synchronous FIFO buffering framed mono samples toward the output stream
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = AUDIO_FIFO_DEPTH,
    parameter int WIDTH = AUDIO_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             rd_ok;
    logic             wr_ok;
    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = mem[rp];
    // Storage needs no reset: the head word is masked by the consumer while empty
    always_ff @(posedge clk)
        if (wr_ok) mem[wp] <= wr_data;
    // Pointers and occupancy; a same-cycle read frees the slot a full-FIFO write needs
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) wp <= (wp == AW'(DEPTH-1)) ? '0 : wp + AW'(1);
            if (rd_ok) rp <= (rp == AW'(DEPTH-1)) ? '0 : rp + AW'(1);
            cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
endmodule

// File: rtl/sample_frame_sequencer.sv
// sample_frame_sequencer: pairs I2S stereo words into mono samples and frames them onto AXI-Stream
module sample_frame_sequencer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH   = AUDIO_DATA_WIDTH,
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int FRAME_LEN    = AUDIO_FRAME_LEN,
    parameter int FIFO_DEPTH   = AUDIO_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic                  busy,
    output logic [15:0]           overflow_count,
    output logic [15:0]           resync_count,
    output logic [15:0]           frame_count
);
    localparam int IW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PAD = DATA_WIDTH - SAMPLE_WIDTH;
    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [IW-1:0]           idx;
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] pend_data;
    logic                    pend_valid;
    logic [SAMPLE_WIDTH-1:0] s_sample;
    logic [SAMPLE_WIDTH:0]   sum;
    logic                    hs;
    logic                    rd;
    logic                    wr;
    logic                    at_last;
    logic                    last_wr;
    logic                    stop_now;
    logic                    launch;
    logic                    bad_order;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH:0]     fifo_din;
    logic [DATA_WIDTH:0]     fifo_dout;
    logic                    unused_bits;
    // The audio source is never back-pressured; ready only drops while in reset
    assign S_AXIS_TREADY = resetn;
    assign hs            = S_AXIS_TVALID & S_AXIS_TREADY;
    assign s_sample      = S_AXIS_TDATA[DATA_WIDTH-1 -: SAMPLE_WIDTH];
    assign sum           = {left[SAMPLE_WIDTH-1], left} + {s_sample[SAMPLE_WIDTH-1], s_sample};
    assign rd            = M_AXIS_TVALID & M_AXIS_TREADY;
    assign wr            = pend_valid & (~fifo_full | rd);
    assign at_last       = (idx == IW'(FRAME_LEN-1));
    assign last_wr       = wr & at_last;
    // Stop immediately only at a clean frame boundary with nothing in flight; otherwise finish the frame
    assign stop_now      = (state != ST_IDLE) & ~enable &
                           (last_wr | ((idx == '0) & ~pend_valid & ((state == ST_LEFT) | (state == ST_ALIGN))));
    assign launch        = (state == ST_RIGHT) & hs & S_AXIS_TLAST & ~stop_now;
    assign bad_order     = hs & (((state == ST_LEFT) & S_AXIS_TLAST) | ((state == ST_RIGHT) & ~S_AXIS_TLAST));
    assign fifo_din      = {at_last, pend_data, {PAD{1'b0}}};
    assign M_AXIS_TVALID = ~fifo_empty;
    assign M_AXIS_TDATA  = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
    assign M_AXIS_TLAST  = ~fifo_empty & fifo_dout[DATA_WIDTH];
    assign busy          = (state != ST_IDLE) | ~fifo_empty;
    assign unused_bits   = ^{S_AXIS_TDATA[PAD-1:0], sum[0]};
    // Channel tracking: align on a right word, then alternate left/right; wrong-order words hold position
    always_comb
        state_nxt = stop_now             ? ST_IDLE :
                    (state == ST_IDLE)   ? (enable ? ST_ALIGN : ST_IDLE) :
                    ~hs                  ? state :
                    (state == ST_LEFT)   ? (S_AXIS_TLAST ? ST_LEFT : ST_RIGHT) :
                    S_AXIS_TLAST         ? ST_LEFT : state;
    // State register
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    // Left-word latch and one-cycle mono pipeline stage feeding the FIFO write
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            left       <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (hs & ~S_AXIS_TLAST & ((state == ST_LEFT) | (state == ST_RIGHT))) left <= s_sample;
            if (launch) pend_data <= sum[SAMPLE_WIDTH:1];
            pend_valid <= launch;
        end
    // Frame index advances only on accepted writes; drop/resync/frame statistics
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            idx            <= '0;
            overflow_count <= '0;
            resync_count   <= '0;
            frame_count    <= '0;
        end else begin
            if (wr) idx <= at_last ? '0 : idx + IW'(1);
            if (last_wr) frame_count <= frame_count + 16'd1;
            if (pend_valid & ~wr) overflow_count <= sat_inc(overflow_count);
            if (bad_order) resync_count <= sat_inc(resync_count);
        end
    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr),
        .wr_data (fifo_din),
        .rd_en   (rd),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
endmodule
